// File: rtl/nios_system_shared_memory_arbiter_pkg.sv
// Shared constants and FSM encoding for the shared-memory port-2 arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nios_system_shm_pkg;

  localparam int SHM_ADDR_W = 10;
  localparam int SHM_DATA_W = 32;
  localparam int SHM_BE_W   = SHM_DATA_W / 8;

  // Width of the tenure counter; holds MAX_HOLD values up to 15.
  localparam int SHM_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } shm_state_t;

endpackage

// File: rtl/nios_system_shared_memory_arbiter_rr_grant.sv
// Round-robin grant decision for two requesters with bounded owner tenure.
// Latency: purely combinational.
// Backpressure: a non-granted requester sees no grant and must hold its request.
module shm_rr_grant
  import nios_system_shm_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic [1:0]           i_req,
  input  shm_state_t           i_state,
  input  logic                 i_last_grant,
  input  logic [SHM_CNT_W-1:0] i_hold_cnt,
  output logic [1:0]           o_grant
);

  localparam logic [SHM_CNT_W-1:0] L_MAX_HOLD = SHM_CNT_W'(MAX_HOLD);

  logic w_hold_ok;

  // The current owner may keep the port while its tenure is below the limit.
  assign w_hold_ok = (i_hold_cnt < L_MAX_HOLD);

  // Pick at most one winner from current ownership, requests and tenure.
  always_comb begin
    o_grant = 2'b00;
    case (i_state)
      ST_OWN0: begin
        if (i_req[0]) begin
          o_grant = (i_req[1] && !w_hold_ok) ? 2'b10 : 2'b01;
        end else if (i_req[1]) begin
          o_grant = 2'b10;
        end
      end
      ST_OWN1: begin
        if (i_req[1]) begin
          o_grant = (i_req[0] && !w_hold_ok) ? 2'b01 : 2'b10;
        end else if (i_req[0]) begin
          o_grant = 2'b01;
        end
      end
      default: begin
        // Tie from idle goes to whoever was not served last.
        if (i_req == 2'b11) begin
          o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else begin
          o_grant = i_req;
        end
      end
    endcase
  end

endmodule

// File: rtl/nios_system_shared_memory_arbiter.sv
// Two-master round-robin arbiter sharing RAM port s2, one beat per cycle.
// Latency: accept in the request cycle; read data returned exactly 1 cycle later.
// Backpressure: loser (and everyone during reset) sees waitrequest=1 and holds.
module nios_system_shared_memory_arbiter
  import nios_system_shm_pkg::*;
#(
  parameter int ADDR_W   = SHM_ADDR_W,
  parameter int DATA_W   = SHM_DATA_W,
  parameter int BE_W     = DATA_W / 8,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  localparam logic [SHM_CNT_W-1:0] L_MAX_HOLD = SHM_CNT_W'(MAX_HOLD);

  shm_state_t           r_state;
  logic                 r_last_grant;
  logic [SHM_CNT_W-1:0] r_hold_cnt;
  logic                 r_rd_pend;
  logic                 r_rd_id;

  shm_state_t           w_state_nxt;
  logic                 w_last_nxt;
  logic [SHM_CNT_W-1:0] w_hold_nxt;
  logic [1:0]           w_req;
  logic [1:0]           w_grant_raw;
  logic [1:0]           w_grant;
  logic                 w_any;
  logic                 w_win;
  logic                 w_win_rd;

  assign w_req = {m1_read | m1_write, m0_read | m0_write};

  shm_rr_grant #(
    .MAX_HOLD (MAX_HOLD)
  ) u_grant (
    .i_req        (w_req),
    .i_state      (r_state),
    .i_last_grant (r_last_grant),
    .i_hold_cnt   (r_hold_cnt),
    .o_grant      (w_grant_raw)
  );

  // Nothing is accepted while reset is high, even a request already waiting.
  assign w_grant = reset ? 2'b00 : w_grant_raw;
  assign w_any   = |w_grant;
  assign w_win   = w_grant[1];

  assign m0_waitrequest = ~w_grant[0];
  assign m1_waitrequest = ~w_grant[1];
  assign mem_chipselect = w_any;
  assign mem_clken      = w_any;

  // Steer the winner's transfer onto the RAM port; read+write counts as write.
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    w_win_rd       = 1'b0;
    if (w_grant[0]) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
      w_win_rd       = m0_read & ~m0_write;
    end else if (w_grant[1]) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
      w_win_rd       = m1_read & ~m1_write;
    end
  end

  // Next ownership, last-served id and tenure count from this cycle's grant.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_last_nxt  = r_last_grant;
    w_hold_nxt  = '0;
    if (w_any) begin
      w_state_nxt = w_win ? ST_OWN1 : ST_OWN0;
      w_last_nxt  = w_win;
      if (w_state_nxt == r_state) begin
        w_hold_nxt = (r_hold_cnt >= L_MAX_HOLD) ? L_MAX_HOLD : r_hold_cnt + 1'b1;
      end else begin
        w_hold_nxt = SHM_CNT_W'(1);
      end
    end
  end

  // State registers plus the one-deep read-return tag; reset drops a pending return.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_hold_cnt   <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_id      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_rd_pend    <= w_win_rd;
      r_rd_id      <= w_win;
    end
  end

  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = r_rd_pend & ~r_rd_id & ~reset;
  assign m1_readdatavalid = r_rd_pend &  r_rd_id & ~reset;

endmodule

// File: tb/tb_nios_system_shared_memory_arbiter.sv
// Bench for the shared-memory arbiter: RAM model, shadow memory, read scoreboard.
// Latency: checks read data arrives exactly one cycle after the accepted beat.
// Backpressure: drives Avalon requests and holds them while waitrequest is high.
module tb_nios_system_shared_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  logic [31:0] bank   [1024];
  logic [31:0] shadow [1024];
  logic        mem_init = 1'b0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  nios_system_shared_memory_arbiter #(.MAX_HOLD(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_byteenable    (m0_byteenable),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_byteenable    (m1_byteenable),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 ^ 32'(i * 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // RAM port-2 model: registered read, byte-lane writes, gated by clken.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) bank[i] <= pat(i);
      mem_init <= 1'b1;
    end else if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) bank[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= bank[mem_address];
      end
    end
  end

  // Scoreboard: every readdatavalid must match the oldest expected read.
  always @(negedge clk) begin
    if (m0_readdatavalid || m1_readdatavalid) begin
      if (m0_readdatavalid && m1_readdatavalid) chk("both_rdv", 1, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_rdv", 1, 0);
      end else begin
        rd_exp_t e;
        e = exp_q.pop_front();
        chk("rdv_id", m1_readdatavalid, e.id);
        chk("rdv_latency", cyc, e.cyc + 1);
        chk("rdata", e.id ? m1_readdata : m0_readdata, e.data);
      end
    end
  end

  task automatic set_port(input logic id, input logic rd, input logic wr,
                          input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wd);
    if (id) begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = wd;
    end else begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = wd;
    end
  endtask

  // Called at the negedge of an accepted beat: check RAM drive, update model.
  task automatic note_accept(input logic id, input logic rd, input logic wr,
                             input logic [9:0] addr, input logic [3:0] be, input logic [31:0] wd);
    rd_exp_t e;
    chk("beat_clken", mem_clken, 1);
    chk("beat_cs", mem_chipselect, 1);
    chk("beat_we", mem_write, wr);
    chk("beat_addr", mem_address, addr);
    chk("beat_be", mem_byteenable, be);
    if (wr) begin
      chk("beat_wdata", mem_writedata, wd);
      for (int b = 0; b < 4; b++)
        if (be[b]) shadow[addr][8*b +: 8] = wd[8*b +: 8];
    end else if (rd) begin
      e.id = id; e.data = shadow[addr]; e.cyc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic xfer(input logic id, input logic rd, input logic wr, input logic [9:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int exp_wait);
    int waited = 0;
    bit ok = 0;
    set_port(id, rd, wr, addr, be, wd);
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (!(id ? m1_waitrequest : m0_waitrequest)) begin
        ok = 1;
        note_accept(id, rd, wr, addr, be, wd);
      end else begin
        waited++;
        @(posedge clk); #1;
      end
    end
    chk("xfer_accepted", ok, 1);
    chk("xfer_wait", waited, exp_wait);
    @(posedge clk); #1;
    set_port(id, 1'b0, 1'b0, '0, '0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [9:0] a0, a1;
    int exp_id;
    for (int i = 0; i < 1024; i++) shadow[i] = pat(i);

    // Reset state.
    @(negedge clk);
    chk("rst_m0_wait", m0_waitrequest, 1);
    chk("rst_m1_wait", m1_waitrequest, 1);
    chk("rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
    chk("rst_mem_ctl", {mem_clken, mem_chipselect, mem_write}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Write by m0, then immediate read-back by m1.
    xfer(1'b0, 1'b0, 1'b1, 10'h005, 4'hF, 32'hDEADBEEF, 0);
    xfer(1'b1, 1'b1, 1'b0, 10'h005, 4'hF, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Both stream reads: tenure of 4 beats each, one beat every cycle.
    a0 = 10'h100; a1 = 10'h200;
    set_port(1'b0, 1'b1, 1'b0, a0, 4'hF, '0);
    set_port(1'b1, 1'b1, 1'b0, a1, 4'hF, '0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_id = (i / 4) % 2;
      chk("rr_m0_wait", m0_waitrequest, exp_id == 1);
      chk("rr_m1_wait", m1_waitrequest, exp_id == 0);
      if (!m0_waitrequest) begin
        note_accept(1'b0, 1'b1, 1'b0, a0, 4'hF, '0);
        a0 = a0 + 10'd1;
      end else if (!m1_waitrequest) begin
        note_accept(1'b1, 1'b1, 1'b0, a1, 4'hF, '0);
        a1 = a1 + 10'd1;
      end else begin
        chk("rr_beat", mem_clken, 1);
      end
      @(posedge clk); #1;
      m0_address = a0;
      m1_address = a1;
    end
    set_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Byte-lane write merge.
    xfer(1'b0, 1'b0, 1'b1, 10'h020, 4'hF, 32'h11223344, 0);
    xfer(1'b0, 1'b0, 1'b1, 10'h020, 4'h2, 32'h0000AB00, 0);
    xfer(1'b1, 1'b1, 1'b0, 10'h020, 4'hF, 32'h0, 0);
    chk("byte_merge_model", shadow[10'h020], 32'h1122AB44);

    // Read and write together behave as a write at the top address.
    xfer(1'b1, 1'b1, 1'b1, 10'h3FF, 4'hF, 32'h0F0F0F0F, 0);
    xfer(1'b0, 1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0, 0);
    repeat (2) @(posedge clk);
    #1;

    // Read accepted, then reset: return dropped, waiting requests blocked.
    set_port(1'b0, 1'b1, 1'b0, 10'h005, 4'hF, '0);
    @(negedge clk);
    chk("pre_rst_accept", m0_waitrequest, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    set_port(1'b0, 1'b1, 1'b0, 10'h006, 4'hF, '0);
    set_port(1'b1, 1'b1, 1'b0, 10'h007, 4'hF, '0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mid_rst_m0_wait", m0_waitrequest, 1);
      chk("mid_rst_m1_wait", m1_waitrequest, 1);
      chk("mid_rst_rdv", {m1_readdatavalid, m0_readdatavalid}, 0);
      chk("mid_rst_mem_ctl", {mem_clken, mem_chipselect, mem_write}, 0);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_m0_wins", m0_waitrequest, 0);
    chk("post_rst_m1_waits", m1_waitrequest, 1);
    if (!m0_waitrequest) note_accept(1'b0, 1'b1, 1'b0, 10'h006, 4'hF, '0);
    @(posedge clk); #1;
    set_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    chk("post_rst_m1_next", m1_waitrequest, 0);
    if (!m1_waitrequest) note_accept(1'b1, 1'b1, 1'b0, 10'h007, 4'hF, '0);
    @(posedge clk); #1;
    set_port(1'b1, 1'b0, 1'b0, '0, '0, '0);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
